// File: rtl/npu_systolic_mm.sv
// ---------------------------------------------------------------------------
// npu_systolic_mm
//
// Output-stationary N x N systolic matrix-multiply tile. It computes
// C = A x B, or C += A x B when acc is set with start.
//
// Operands are captured on the start edge. The tile then runs a RUN phase of
// 3N-2 cycles in which skewed rows of A enter from the left and skewed
// columns of B enter from the top. Each processing element multiplies the
// pair of operands passing through it and adds the product to its own
// accumulator. A one-cycle DRAIN phase then copies every accumulator into
// the registered output C and pulses done.
//
// Build option:
//   NPU_SIGNED_EN  defined   -> A, B and C are two's-complement
//                  undefined -> all operands and results are unsigned
//
// Parameters:
//   N   array dimension (N >= 2)
//   DW  operand element width
//   OW  accumulator / result element width (>= 2*DW + clog2(N))
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous reset, active low
//   start  request an operation; honoured only while idle
//   acc    sampled with start: 1 accumulates onto C, 0 overwrites C
//   A, B   operand matrices, indexed [row][col]
//   busy   high while an operation is in flight
//   done   one-cycle pulse after C has been updated
//   C      registered result matrix, indexed [row][col]
// ---------------------------------------------------------------------------
module npu_systolic_mm #(
   parameter int N  = 2,
   parameter int DW = 8,
   parameter int OW = 2*DW+8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            acc,
   input  logic [N-1:0][N-1:0][DW-1:0]     A,
   input  logic [N-1:0][N-1:0][DW-1:0]     B,
   output logic                            busy,
   output logic                            done,
   output logic [N-1:0][N-1:0][OW-1:0]     C
);

   // The last feed step is 3N-3, so the step counter needs to hold 0..3N-3.
   localparam int LAST = 3*N-3;
   localparam int SW   = $clog2(3*N-2);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [SW-1:0]                  step;
   logic [N-1:0][N-1:0][DW-1:0]    op_a;
   logic [N-1:0][N-1:0][DW-1:0]    op_b;
   logic [N-1:0][DW-1:0]           a_feed;
   logic [N-1:0][DW-1:0]           b_feed;
   logic [N-1:0][N-2:0][DW-1:0]    a_pipe;
   logic [N-2:0][N-1:0][DW-1:0]    b_pipe;
   logic [N-1:0][N-1:0][OW-1:0]    acc_sum;
   logic                           load;
   logic                           run;
   logic                           drain;

   // Widen a DW x DW product to the accumulator width. The product is
   // sign-extended in the signed build and zero-extended otherwise.
   function automatic logic [OW-1:0] mac_product(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
`ifdef NPU_SIGNED_EN
      logic signed [2*DW-1:0] p;
      p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
      return {{(OW-2*DW){p[2*DW-1]}}, p};
`else
      logic [2*DW-1:0] p;
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return {{(OW-2*DW){1'b0}}, p};
`endif
   endfunction

   assign load  = (state == IDLE) && start;
   assign run   = (state == RUN);
   assign drain = (state == DRAIN);
   assign busy  = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. The tile leaves RUN after the final feed step.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (step == SW'(LAST)) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Skewed edge feeds. At step t, row i receives A[i][t-i] and column j
   // receives B[t-j][j]. Any index outside the matrix feeds zero, which
   // provides the padding for the diagonal wavefront.
   always_comb begin
      a_feed = '0;
      b_feed = '0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (int'(step) == i + k) begin
               a_feed[i] = op_a[i][k];
               b_feed[i] = op_b[k][i];
            end
         end
      end
   end

   // Operand capture, step counter, result register and done pulse.
   // done is registered from DRAIN, so it is high for the cycle after the
   // edge on which C is written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_a <= '0;
         op_b <= '0;
         step <= '0;
         C    <= '0;
         done <= 1'b0;
      end else begin
         done <= drain;
         if (load) begin
            op_a <= A;
            op_b <= B;
            step <= '0;
         end else if (run) begin
            step <= step + SW'(1);
         end
         if (drain) begin
            C <= acc_sum;
         end
      end
   end

   // Processing-element grid. Each PE keeps its own accumulator. It also
   // forwards its operands right and down, except at the last column and
   // the last row, where nothing consumes them.
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [DW-1:0] a_in;
         logic [DW-1:0] b_in;
         logic [OW-1:0] sum_q;

         if (gj == 0) begin : g_a_edge
            assign a_in = a_feed[gi];
         end else begin : g_a_inner
            assign a_in = a_pipe[gi][gj-1];
         end

         if (gi == 0) begin : g_b_edge
            assign b_in = b_feed[gj];
         end else begin : g_b_inner
            assign b_in = b_pipe[gi-1][gj];
         end

         // Accumulator. It is cleared or preloaded from C at start, then
         // adds one product per RUN cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sum_q <= '0;
            end else if (load) begin
               sum_q <= acc ? C[gi][gj] : '0;
            end else if (run) begin
               sum_q <= sum_q + mac_product(a_in, b_in);
            end
         end
         assign acc_sum[gi][gj] = sum_q;

         if (gj < N-1) begin : g_fwd_a
            logic [DW-1:0] a_q;
            // Horizontal operand pipeline, flushed at start so padding is zero.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  a_q <= '0;
               end else if (load) begin
                  a_q <= '0;
               end else if (run) begin
                  a_q <= a_in;
               end
            end
            assign a_pipe[gi][gj] = a_q;
         end

         if (gi < N-1) begin : g_fwd_b
            logic [DW-1:0] b_q;
            // Vertical operand pipeline, flushed at start so padding is zero.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  b_q <= '0;
               end else if (load) begin
                  b_q <= '0;
               end else if (run) begin
                  b_q <= b_in;
               end
            end
            assign b_pipe[gi][gj] = b_q;
         end
      end
   end

endmodule

// File: tb/tb_npu_systolic_mm.sv
// ---------------------------------------------------------------------------
// tb_npu_systolic_mm
//
// Directed self-checking bench for npu_systolic_mm with N=2, DW=8, OW=24.
// Each scenario task drives its own stimulus and compares DUT outputs
// against hand-computed values. Expectations that depend on NPU_SIGNED_EN
// follow the same macro.
// ---------------------------------------------------------------------------
module tb_npu_systolic_mm;

   localparam int N        = 2;
   localparam int DW       = 8;
   localparam int OW       = 24;
   localparam int MAX_WAIT = 20;

   typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
   typedef logic [OW-1:0] res_t [N][N];

   localparam mat_t MAT_A1 = {{8'd4, 8'd3}, {8'd2, 8'd1}};
   localparam mat_t MAT_B1 = {{8'd8, 8'd7}, {8'd6, 8'd5}};

   logic                         clk   = 1'b0;
   logic                         rst   = 1'b0;
   logic                         start = 1'b0;
   logic                         acc   = 1'b0;
   mat_t                         A     = '0;
   mat_t                         B     = '0;
   logic                         busy;
   logic                         done;
   logic [N-1:0][N-1:0][OW-1:0]  C;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   npu_systolic_mm #(.N(N), .DW(DW), .OW(OW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .acc   (acc),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .C     (C)
   );

   // Present operands and a one-cycle start pulse. Returns 1 ns after the
   // start edge.
   task automatic kick(input mat_t a_in, input mat_t b_in, input logic acc_in);
      A     = a_in;
      B     = b_in;
      acc   = acc_in;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after the start edge until done is seen, bounded by
   // MAX_WAIT. Also counts busy-high samples seen before done.
   task automatic wait_done(output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = 0;
      while (edges < MAX_WAIT) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) break;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_busy got=%b want=0", busy);
      end
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_done got=%b want=0", done);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== '0) begin
               bad++;
               $display("[TB] FAIL reset_c[%0d][%0d] got=%0d want=0", i, j, C[i][j]);
            end
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release_busy got=%b want=0", busy);
      end
   endtask

   // Scenario 1: plain multiply. Returns on the cycle in which done is high.
   task automatic test_basic();
      int   edges;
      int   busy_cnt;
      res_t exp_c;
      exp_c = '{'{24'd19, 24'd22}, '{24'd43, 24'd50}};
      kick(MAT_A1, MAT_B1, 1'b0);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_busy_after_start got=%b want=1", busy);
      end
      wait_done(edges, busy_cnt);
      total++;
      if (edges !== 5) begin
         bad++;
         $display("[TB] FAIL basic_latency got=%0d want=5", edges);
      end
      total++;
      if (busy_cnt !== 4) begin
         bad++;
         $display("[TB] FAIL basic_busy_cycles got=%0d want=4", busy_cnt);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_busy_at_done got=%b want=0", busy);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== exp_c[i][j]) begin
               bad++;
               $display("[TB] FAIL basic_c[%0d][%0d] got=%0d want=%0d", i, j, C[i][j], exp_c[i][j]);
            end
         end
      end
   endtask

   // Scenario 2: accumulate, started on the done cycle of scenario 1.
   task automatic test_back_to_back();
      int   edges;
      int   busy_cnt;
      res_t exp_c;
      exp_c = '{'{24'd38, 24'd44}, '{24'd86, 24'd100}};
      kick(MAT_A1, MAT_B1, 1'b1);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_done_single_cycle got=%b want=0", done);
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_accepted got=%b want=1", busy);
      end
      wait_done(edges, busy_cnt);
      total++;
      if (edges !== 5) begin
         bad++;
         $display("[TB] FAIL b2b_latency got=%0d want=5", edges);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== exp_c[i][j]) begin
               bad++;
               $display("[TB] FAIL b2b_c[%0d][%0d] got=%0d want=%0d", i, j, C[i][j], exp_c[i][j]);
            end
         end
      end
   endtask

   // Scenario 3: start, A and acc change while busy and must be ignored.
   task automatic test_busy_ignore();
      int   n_done;
      res_t exp_c;
      exp_c  = '{'{24'd19, 24'd22}, '{24'd43, 24'd50}};
      n_done = 0;
      kick(MAT_A1, MAT_B1, 1'b0);
      @(posedge clk);
      #1;
      A     = {4{8'd9}};
      acc   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (done) n_done++;
      @(posedge clk);
      #1;
      if (done) n_done++;
      start = 1'b0;
      repeat (MAX_WAIT) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      total++;
      if (n_done !== 1) begin
         bad++;
         $display("[TB] FAIL ignore_done_count got=%0d want=1", n_done);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ignore_busy_end got=%b want=0", busy);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== exp_c[i][j]) begin
               bad++;
               $display("[TB] FAIL ignore_c[%0d][%0d] got=%0d want=%0d", i, j, C[i][j], exp_c[i][j]);
            end
         end
      end
      A   = MAT_A1;
      acc = 1'b0;
   endtask

   // Scenario 4: all-ones operands. There is no wrap at OW=24 unsigned.
   task automatic test_max();
      int          edges;
      int          busy_cnt;
      logic [OW-1:0] want;
`ifdef NPU_SIGNED_EN
      want = 24'd2;
`else
      want = 24'd130050;
`endif
      kick({4{8'd255}}, {4{8'd255}}, 1'b0);
      wait_done(edges, busy_cnt);
      total++;
      if (edges !== 5) begin
         bad++;
         $display("[TB] FAIL max_latency got=%0d want=5", edges);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== want) begin
               bad++;
               $display("[TB] FAIL max_c[%0d][%0d] got=%0d want=%0d", i, j, C[i][j], want);
            end
         end
      end
   endtask

   // Scenario 5: reset two cycles into an operation, then a clean run.
   task automatic test_reset_abort();
      int   edges;
      int   busy_cnt;
      int   n_done;
      res_t exp_c;
      exp_c  = '{'{24'd19, 24'd22}, '{24'd43, 24'd50}};
      n_done = 0;
      kick(MAT_A1, MAT_B1, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_busy got=%b want=0", busy);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== '0) begin
               bad++;
               $display("[TB] FAIL abort_c[%0d][%0d] got=%0d want=0", i, j, C[i][j]);
            end
         end
      end
      @(posedge clk);
      #1;
      if (done) n_done++;
      rst = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      total++;
      if (n_done !== 0) begin
         bad++;
         $display("[TB] FAIL abort_no_done got=%0d want=0", n_done);
      end
      kick(MAT_A1, MAT_B1, 1'b0);
      wait_done(edges, busy_cnt);
      total++;
      if (edges !== 5) begin
         bad++;
         $display("[TB] FAIL abort_rerun_latency got=%0d want=5", edges);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== exp_c[i][j]) begin
               bad++;
               $display("[TB] FAIL abort_rerun_c[%0d][%0d] got=%0d want=%0d", i, j, C[i][j], exp_c[i][j]);
            end
         end
      end
   endtask

   // Scenario 6: 8'hFF times 2. The result is -4 signed or 1020 unsigned.
   task automatic test_signedness();
      int          edges;
      int          busy_cnt;
      logic [OW-1:0] want;
`ifdef NPU_SIGNED_EN
      want = 24'hFFFFFC;
`else
      want = 24'd1020;
`endif
      kick({4{8'hFF}}, {4{8'd2}}, 1'b0);
      wait_done(edges, busy_cnt);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            total++;
            if (C[i][j] !== want) begin
               bad++;
               $display("[TB] FAIL sign_c[%0d][%0d] got=%h want=%h", i, j, C[i][j], want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_ignore();
      test_max();
      test_reset_abort();
      test_signedness();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
